product_bcd_converter: RTL and testbench
========================================

PRODUCT_BCD_CONVERTER -- requirements
Module: product_bcd_converter

Interface
REQ-001 Parameters SHALL be: WIDTH, 16, product width in bits; DIGITS, 5, number of BCD output digits; only the defaults need to be supported.
REQ-002 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port clr  input  1  reset, asynchronous, active-low.
REQ-004 Port over  input  1  completion flag from the upstream Booth multiplier; a level, not a pulse.
REQ-005 Port product  input  16  signed two's-complement product; stable whenever over is high.
REQ-006 Port busy  output  1  conversion in progress.
REQ-007 Port valid  output  1  sign/bcd hold a completed result.
REQ-008 Port sign  output  1  1 when the captured product was negative.
REQ-009 Port bcd  output  20  magnitude as 5 BCD digits; bcd[3:0] is the units digit.

Function
REQ-010 The block SHALL register over into over_q each cycle; start = over & ~over_q.
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-012 IDLE: on start, SHALL capture sign = product[15] and mag = |product| (16-bit unsigned), clear the 20-bit BCD shift register, load the iteration counter with 16, and go to SHIFT; otherwise remain in IDLE.
REQ-013 Magnitude SHALL be computed as ~product+1 when product[15]=1; 0x8000 SHALL yield mag 32768 without overflow.
REQ-014 SHIFT: each cycle SHALL add 3 to every BCD digit >= 5, then shift {bcd_sr, mag} left by one bit, and decrement the counter.
REQ-015 When the counter reaches 0 (16th SHIFT cycle), the FSM SHALL load the bcd output from the shift register, set valid=1, and go to DONE.
REQ-016 Latency: valid SHALL rise exactly 16 clock edges after the capture edge.
REQ-017 busy SHALL be 1 in SHIFT and 0 in IDLE and DONE.
REQ-018 A start occurring during SHIFT SHALL be ignored; over_q keeps tracking over.
REQ-019 DONE: the FSM SHALL go to IDLE when over is sampled low; otherwise it SHALL remain in DONE.
REQ-020 sign, bcd and valid SHALL hold their values in DONE and IDLE until the next capture edge.
REQ-021 On the next capture edge, valid SHALL fall to 0 and sign SHALL update; bcd SHALL update only at completion.
REQ-022 If over rises and falls within one cycle between edges, no start SHALL occur; only sampled levels count.
REQ-023 Every bcd digit SHALL always be in the range 0-9; maximum output is 32768.

Reset
REQ-024 When clr=0, the block SHALL immediately force state=IDLE, over_q=0, busy=0, valid=0, sign=0, bcd=0, counter=0, and the internal registers to 0.
REQ-025 A reset during SHIFT SHALL abort the conversion; no partial result SHALL become visible.
REQ-026 Because over_q resets to 0, if over is high at the first edge after clr rises, that edge SHALL be a capture edge.

Verification
REQ-027 product=0x0055 (17*5), over rising -> busy for 16 cycles, then valid=1, sign=0, bcd=0x00085.
REQ-028 product=0xFFFF -> sign=1, bcd=0x00001; product=0x8000 -> sign=1, bcd=0x32768; product=0x7FFF -> sign=0, bcd=0x32767.
REQ-029 product=0x0000 -> sign=0, bcd=0x00000, valid=1 after 16 cycles.
REQ-030 clr pulsed low at the 8th SHIFT cycle -> all outputs 0 immediately; with over held high, a new capture occurs on the first edge after release, and the full result appears 16 cycles later.
REQ-031 over toggled low then high during SHIFT -> the in-flight result completes unchanged; no second conversion starts; the FSM enters DONE and reaches IDLE only once over is low.
REQ-032 Back-to-back runs 85 then -2 (0xFFFE) with over dropping between them -> second result sign=1, bcd=0x00002; valid is low during the second SHIFT.

Source files
------------

// File: rtl/product_bcd_converter_if.sv
`default_nettype none
// ============================================================================
// Module      : product_bcd_converter_if
// Description : Bundles the upstream multiplier handshake (over, product) and
//               the converter result (busy, valid, sign, bcd).
//               master : upstream side, drives over/product, observes results
//               slave  : converter side, observes over/product, drives results
// Revision    : 1.0 - initial release
// ============================================================================
interface product_bcd_converter_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  over;     // completion level from the multiplier
  logic [WIDTH-1:0]      product;  // signed product, stable while over=1
  logic                  busy;     // conversion in progress
  logic                  valid;    // sign/bcd hold a completed result
  logic                  sign;     // captured product was negative
  logic [4*DIGITS-1:0]   bcd;      // magnitude, bcd[3:0] = units digit

  modport master (
    output over,
    output product,
    input  busy,
    input  valid,
    input  sign,
    input  bcd
  );

  modport slave (
    input  over,
    input  product,
    output busy,
    output valid,
    output sign,
    output bcd
  );
endinterface
`default_nettype wire

// File: rtl/product_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module      : product_bcd_converter
// Description : Converts a signed two's-complement product into a sign flag
//               plus a packed-BCD magnitude using the shift-add-3 (double
//               dabble) algorithm, one bit per clock.
//               Ports:
//                 clk  - clock, rising edge
//                 clr  - asynchronous active-low reset
//                 bus  - slave modport: over/product in, busy/valid/sign/bcd out
//               A conversion starts on the rising edge of the sampled "over"
//               level and finishes WIDTH clocks later.
// Revision    : 1.0 - initial release
// ============================================================================
module product_bcd_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  wire logic                 clk,
  input  wire logic                 clr,
  product_bcd_converter_if.slave    bus
);

  localparam int c_BCD_W = 4 * DIGITS;
  localparam int c_TOT_W = c_BCD_W + WIDTH;
  localparam int c_CNT_W = $clog2(WIDTH + 1);

  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(WIDTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_next_state;
  logic                r_over_q;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_BCD_W-1:0]  r_sr;
  logic [WIDTH-1:0]    r_mag;
  logic                r_sign;
  logic                r_valid;
  logic [c_BCD_W-1:0]  r_bcd;

  logic                w_start;
  logic                w_last;
  logic                w_busy;
  logic [WIDTH-1:0]    w_mag;
  logic [c_BCD_W-1:0]  w_adj;
  logic [c_TOT_W-1:0]  w_shifted;

  // Edge of the sampled level only; glitches between edges never start a run.
  assign w_start = bus.over & ~r_over_q;

  // Counter holds 1 during the final SHIFT cycle; it reaches 0 on that edge.
  assign w_last  = (r_cnt == c_CNT_ONE);

  // Unsigned magnitude. The most negative value maps onto itself, which read
  // as unsigned is exactly 2^(WIDTH-1), so no extra bit is required.
  assign w_mag = bus.product[WIDTH-1] ? (~bus.product + 1'b1) : bus.product;

  // Add-3 correction: any digit >= 5 would become >= 10 after doubling.
  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    logic [3:0] w_dig;
    assign w_dig = r_sr[4*d +: 4];
    assign w_adj[4*d +: 4] = (w_dig >= 4'd5) ? (w_dig + 4'd3) : w_dig;
  end

  assign w_shifted = {w_adj, r_mag} << 1;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (w_start)   w_next_state = c_SHIFT;
      c_SHIFT: if (w_last)    w_next_state = c_DONE;
      c_DONE:  if (!bus.over) w_next_state = c_IDLE;
      default:                w_next_state = c_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_busy = 1'b0;
    if (r_state == c_SHIFT) begin
      w_busy = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_over_q <= 1'b0;
      r_cnt    <= '0;
      r_sr     <= '0;
      r_mag    <= '0;
      r_sign   <= 1'b0;
      r_valid  <= 1'b0;
      r_bcd    <= '0;
    end else begin
      // over_q tracks over in every state, so a re-rise during SHIFT is
      // consumed there and cannot trigger a capture once back in IDLE.
      r_over_q <= bus.over;
      case (r_state)
        c_IDLE: begin
          if (w_start) begin
            r_sign  <= bus.product[WIDTH-1];
            r_mag   <= w_mag;
            r_sr    <= '0;
            r_cnt   <= c_CNT_LOAD;
            r_valid <= 1'b0;
          end
        end
        c_SHIFT: begin
          {r_sr, r_mag} <= w_shifted;
          r_cnt         <= r_cnt - 1'b1;
          // bcd is only ever loaded from a finished conversion.
          if (w_last) begin
            r_bcd   <= w_shifted[c_TOT_W-1 -: c_BCD_W];
            r_valid <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy  = w_busy;
  assign bus.valid = r_valid;
  assign bus.sign  = r_sign;
  assign bus.bcd   = r_bcd;

endmodule
`default_nettype wire

// File: tb/tb_product_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module      : tb_product_bcd_converter
// Description : Directed self-checking bench for product_bcd_converter.
//               Drives over/product through the interface and compares
//               busy/valid/sign/bcd against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_product_bcd_converter;

  logic        clk = 1'b0;
  logic        clr;
  int          total = 0;
  int          bad   = 0;
  logic [19:0] last_bcd = 20'h0;

  product_bcd_converter_if #(.WIDTH(16), .DIGITS(5)) bus ();

  product_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clr         = 1'b0;
    bus.over    = 1'b1;
    bus.product = 16'h8000;
    repeat (3) tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.valid); end
    total++; if (bus.sign !== 1'b0) begin bad++; $display("FAIL rst_sign: got %b want 0", bus.sign); end
    total++; if (bus.bcd !== 20'h0) begin bad++; $display("FAIL rst_bcd: got %h want 00000", bus.bcd); end
    bus.over = 1'b0;
    clr      = 1'b1;
    tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_idle_busy: got %b want 0", bus.busy); end
  endtask

  // Full conversion from IDLE: capture, 16 edges of SHIFT, DONE hold, IDLE hold.
  task automatic test_conversion(input logic [15:0] p, input logic s,
                                 input logic [19:0] b, input string name);
    bus.over = 1'b0;
    tick();
    tick();
    bus.product = p;
    bus.over    = 1'b1;
    tick();  // capture edge
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL %s_cap_busy: got %b want 1", name, bus.busy); end
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL %s_cap_valid: got %b want 0", name, bus.valid); end
    total++; if (bus.sign !== s) begin bad++; $display("FAIL %s_cap_sign: got %b want %b", name, bus.sign, s); end
    total++; if (bus.bcd !== last_bcd) begin bad++; $display("FAIL %s_cap_bcd_held: got %h want %h", name, bus.bcd, last_bcd); end
    for (int i = 1; i <= 15; i++) begin
      tick();
      total++;
      if (bus.busy !== 1'b1 || bus.valid !== 1'b0) begin
        bad++;
        $display("FAIL %s_shift%0d: got busy=%b valid=%b want busy=1 valid=0", name, i, bus.busy, bus.valid);
      end
    end
    tick();  // 16th edge after capture
    total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL %s_done_valid: got %b want 1", name, bus.valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL %s_done_busy: got %b want 0", name, bus.busy); end
    total++; if (bus.sign !== s) begin bad++; $display("FAIL %s_done_sign: got %b want %b", name, bus.sign, s); end
    total++; if (bus.bcd !== b) begin bad++; $display("FAIL %s_done_bcd: got %h want %h", name, bus.bcd, b); end
    tick();
    tick();
    total++;
    if (bus.valid !== 1'b1 || bus.busy !== 1'b0 || bus.bcd !== b) begin
      bad++;
      $display("FAIL %s_done_hold: got valid=%b busy=%b bcd=%h want 1 0 %h", name, bus.valid, bus.busy, bus.bcd, b);
    end
    bus.over = 1'b0;
    tick();
    total++;
    if (bus.valid !== 1'b1 || bus.busy !== 1'b0 || bus.bcd !== b || bus.sign !== s) begin
      bad++;
      $display("FAIL %s_idle_hold: got valid=%b busy=%b sign=%b bcd=%h want 1 0 %b %h",
               name, bus.valid, bus.busy, bus.sign, bus.bcd, s, b);
    end
    last_bcd = b;
  endtask

  task automatic test_glitch;
    bus.over = 1'b0;
    tick();
    #1 bus.over = 1'b1;
    #3 bus.over = 1'b0;
    repeat (3) begin
      tick();
      total++;
      if (bus.busy !== 1'b0 || bus.valid !== 1'b1 || bus.bcd !== last_bcd) begin
        bad++;
        $display("FAIL glitch: got busy=%b valid=%b bcd=%h want 0 1 %h", bus.busy, bus.valid, bus.bcd, last_bcd);
      end
    end
  endtask

  task automatic test_reset_mid_shift;
    bus.over = 1'b0;
    tick();
    tick();
    bus.product = 16'hFFFE;
    bus.over    = 1'b1;
    tick();            // capture
    repeat (7) tick(); // well inside SHIFT
    #3 clr = 1'b0;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.sign !== 1'b0 || bus.bcd !== 20'h0) begin
      bad++;
      $display("FAIL midrst_clear: got busy=%b valid=%b sign=%b bcd=%h want 0 0 0 00000",
               bus.busy, bus.valid, bus.sign, bus.bcd);
    end
    #1 clr = 1'b1;
    tick();  // first edge after release, over still high -> capture
    total++;
    if (bus.busy !== 1'b1 || bus.sign !== 1'b1 || bus.valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_recapture: got busy=%b sign=%b valid=%b want 1 1 0", bus.busy, bus.sign, bus.valid);
    end
    repeat (15) tick();
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL midrst_early_valid: got %b want 0", bus.valid); end
    tick();
    total++;
    if (bus.valid !== 1'b1 || bus.bcd !== 20'h00002 || bus.sign !== 1'b1) begin
      bad++;
      $display("FAIL midrst_result: got valid=%b sign=%b bcd=%h want 1 1 00002", bus.valid, bus.sign, bus.bcd);
    end
    bus.over = 1'b0;
    tick();
    last_bcd = 20'h00002;
  endtask

  task automatic test_over_toggle;
    bus.over = 1'b0;
    tick();
    tick();
    bus.product = 16'h7FFF;
    bus.over    = 1'b1;
    tick();  // capture
    for (int i = 1; i <= 15; i++) begin
      tick();
      total++;
      if (bus.busy !== 1'b1 || bus.valid !== 1'b0) begin
        bad++;
        $display("FAIL toggle_shift%0d: got busy=%b valid=%b want 1 0", i, bus.busy, bus.valid);
      end
      if (i == 5) bus.over = 1'b0;
      if (i == 6) bus.over = 1'b1;
    end
    tick();
    total++;
    if (bus.valid !== 1'b1 || bus.bcd !== 20'h32767 || bus.sign !== 1'b0) begin
      bad++;
      $display("FAIL toggle_result: got valid=%b sign=%b bcd=%h want 1 0 32767", bus.valid, bus.sign, bus.bcd);
    end
    repeat (4) tick();
    total++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b1 || bus.bcd !== 20'h32767) begin
      bad++;
      $display("FAIL toggle_no_restart: got busy=%b valid=%b bcd=%h want 0 1 32767", bus.busy, bus.valid, bus.bcd);
    end
    bus.over = 1'b0;
    tick();  // DONE -> IDLE
    bus.over = 1'b1;
    tick();  // capture from IDLE proves the return to IDLE
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL toggle_reidle: got busy=%b want 1", bus.busy); end
    repeat (16) tick();
    total++;
    if (bus.valid !== 1'b1 || bus.bcd !== 20'h32767) begin
      bad++;
      $display("FAIL toggle_second: got valid=%b bcd=%h want 1 32767", bus.valid, bus.bcd);
    end
    bus.over = 1'b0;
    tick();
    last_bcd = 20'h32767;
  endtask

  task automatic test_back_to_back;
    test_conversion(16'h0055, 1'b0, 20'h00085, "b2b_first");
    test_conversion(16'hFFFE, 1'b1, 20'h00002, "b2b_second");
  endtask

  initial begin
    clr         = 1'b0;
    bus.over    = 1'b0;
    bus.product = 16'h0000;
    test_reset();
    test_conversion(16'h0055, 1'b0, 20'h00085, "p85");
    test_conversion(16'hFFFF, 1'b1, 20'h00001, "neg1");
    test_conversion(16'h8000, 1'b1, 20'h32768, "minneg");
    test_conversion(16'h7FFF, 1'b0, 20'h32767, "maxpos");
    test_conversion(16'h0000, 1'b0, 20'h00000, "zero");
    test_glitch();
    test_reset_mid_shift();
    test_over_toggle();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
